// File: rtl/br_wr_arbiter_pkg.sv
// rtl/br_wr_arbiter_pkg.sv - shared BR widths and register constants
package br_wr_arbiter_pkg;

  localparam int BR_XLEN  = 32;
  localparam int BR_AW    = 5;
  localparam int BR_CW    = 16;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/br_wr_slot.sv
// rtl/br_wr_slot.sv - one-entry pending write slot with x0 drop and read-address match
module br_wr_slot
  import br_wr_arbiter_pkg::*;
#(
  parameter int XLEN = BR_XLEN,
  parameter int AW   = BR_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [AW-1:0]   push_addr,
  input  logic [XLEN-1:0] push_data,
  input  logic            clear,
  input  logic [AW-1:0]   qa1,
  input  logic [AW-1:0]   qa2,
  output logic            v,
  output logic [AW-1:0]   addr,
  output logic [XLEN-1:0] data,
  output logic            match1,
  output logic            match2
);

  logic keep;

  // Writes to x0 complete the handshake but never occupy the slot.
  assign keep = push && (push_addr != AW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v    <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (keep) begin
      v    <= 1'b1;
      addr <= push_addr;
      data <= push_data;
    end else if (clear) begin
      v <= 1'b0;
    end
  end

  assign match1 = v && (qa1 != AW'(REG_ZERO)) && (addr == qa1);
  assign match2 = v && (qa2 != AW'(REG_ZERO)) && (addr == qa2);

endmodule

// File: rtl/br_wr_arbiter.sv
// rtl/br_wr_arbiter.sv - round-robin arbiter sharing the BR write port between two writeback sources
module br_wr_arbiter
  import br_wr_arbiter_pkg::*;
#(
  parameter int XLEN = BR_XLEN,
  parameter int AW   = BR_AW,
  parameter int CW   = BR_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic [AW-1:0]   qa1,
  input  logic [AW-1:0]   qa2,
  output logic            stall1,
  output logic            stall2,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3,
  output logic            we,
  output logic [CW-1:0]   conflict_cnt
);

  logic            s0_v, s1_v;
  logic [AW-1:0]   s0_addr, s1_addr;
  logic [XLEN-1:0] s0_data, s1_data;
  logic            s0_m1, s0_m2, s1_m1, s1_m2;
  logic            gnt0, gnt1;
  logic            prio;

  // Grants are masked during reset so a slot being discarded never reaches BR.
  assign gnt0 = rst_n && s0_v && (!s1_v || !prio);
  assign gnt1 = rst_n && s1_v && (!s0_v ||  prio);

  assign req0_ready = rst_n && (!s0_v || gnt0);
  assign req1_ready = rst_n && (!s1_v || gnt1);

  br_wr_slot #(.XLEN(XLEN), .AW(AW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req0_valid && req0_ready),
    .push_addr (req0_addr),
    .push_data (req0_data),
    .clear     (gnt0),
    .qa1       (qa1),
    .qa2       (qa2),
    .v         (s0_v),
    .addr      (s0_addr),
    .data      (s0_data),
    .match1    (s0_m1),
    .match2    (s0_m2)
  );

  br_wr_slot #(.XLEN(XLEN), .AW(AW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req1_valid && req1_ready),
    .push_addr (req1_addr),
    .push_data (req1_data),
    .clear     (gnt1),
    .qa1       (qa1),
    .qa2       (qa2),
    .v         (s1_v),
    .addr      (s1_addr),
    .data      (s1_data),
    .match1    (s1_m1),
    .match2    (s1_m2)
  );

  always_comb begin
    we  = gnt0 || gnt1;
    a3  = '0;
    wd3 = '0;
    if (gnt0) begin
      a3  = s0_addr;
      wd3 = s0_data;
    end else if (gnt1) begin
      a3  = s1_addr;
      wd3 = s1_data;
    end
  end

  assign stall1 = s0_m1 || s1_m1;
  assign stall2 = s0_m2 || s1_m2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
      if (s0_v && s1_v && (conflict_cnt != {CW{1'b1}}))
        conflict_cnt <= conflict_cnt + CW'(1);
    end
  end

endmodule

// File: doc/br_wr_arbiter.md
Name: br_wr_arbiter

Overview:
- Shares the single write port of the BR register file (a3/wd3/we) between two writeback requesters: req0 (ALU/immediate result) and req1 (load/memory result).
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- Pending slots are arbitrated round-robin onto the BR write port.
- The block also raises read-after-write stall flags when a BR read address targets a register that still has a pending write.
- Sits between the writeback sources and BR, alongside the control unit.

Parameters:
- XLEN, 32, data width of wd3 and request data.
- AW, 5, register address width (32 registers).
- CW, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write to offer.
- req0_addr  in  AW  destination register for requester 0.
- req0_data  in  XLEN  write data for requester 0.
- req0_ready  out  1  requester 0 transfer accepted this cycle when req0_valid is also high.
- req1_valid  in  1  requester 1 has a write to offer.
- req1_addr  in  AW  destination register for requester 1.
- req1_data  in  XLEN  write data for requester 1.
- req1_ready  out  1  requester 1 handshake ready.
- qa1  in  AW  BR read address 1 (mirrors BR a1).
- qa2  in  AW  BR read address 2 (mirrors BR a2).
- stall1  out  1  qa1 matches a pending slot.
- stall2  out  1  qa2 matches a pending slot.
- a3  out  AW  BR write address.
- wd3  out  XLEN  BR write data.
- we  out  1  BR write enable.
- conflict_cnt  out  CW  saturating count of cycles with both slots pending.

Behaviour:
- State:
  - slot0 and slot1, each holding {v, addr, data}.
  - prio, 1 bit: the requester favoured on conflict.
  - conflict_cnt.
- Reset (rst_n low at a rising edge):
  - slot0.v and slot1.v cleared, prio = 0, conflict_cnt = 0.
  - Pending slot contents are discarded and never written.
  - While rst_n is low, req0_ready = req1_ready = 0. we, stall1 and stall2 are 0 after the first reset edge.
- Grant (combinational):
  - Only slot0.v set: grant 0.
  - Only slot1.v set: grant 1.
  - Both set: grant = prio.
  - Neither set: no grant.
- Write port (combinational from the granted slot):
  - we = 1 whenever a grant exists; a3 and wd3 come from the granted slot.
  - With no grant: we = 0, a3 = 0, wd3 = 0.
  - BR commits the write at the end of that cycle.
- Slot update at each rising edge:
  - A granted slot is cleared.
  - A slot is loaded when reqN_valid && reqN_ready && reqN_addr != 0.
  - Load and clear in the same edge: the load wins, giving back-to-back throughput.
- Ready: reqN_ready = rst_n && (!slotN.v || grantN). This is combinational, with no dependency on reqN_valid.
- Latency: a request accepted at edge E is written into BR at edge E+1 if uncontested; worst case E+2.
- Writes to x0: a request with addr == 0 is handshaken (ready as above) but not loaded. No BR write is ever issued for x0.
- prio update at each edge where a grant occurs: prio = !granted requester. With no grant, prio holds.
- Same destination in both slots:
  - Both writes are issued in grant order; the later grant determines the final BR contents.
  - Requesters needing ordering must not present conflicting writes in the same cycle.
- Stall flags:
  - stall1 = qa1 != 0 && ((slot0.v && slot0.addr == qa1) || (slot1.v && slot1.addr == qa1)). stall2 is the same using qa2.
  - The flags are combinational and are still asserted in the cycle a matching slot is being written; they clear the next cycle.
- conflict_cnt increments on each edge where slot0.v && slot1.v, and saturates at all-ones.

Decomposition:
- Shared package / include file: the XLEN and AW constants, which are also used by BR and the datapath, and the REG_ZERO = 0 constant.
- One natural sub-module: br_wr_slot. It is instantiated twice and holds v/addr/data with load, clear and x0-drop logic, and exposes v, addr, data and a match output for the two query ports.
- The round-robin pointer and counter stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req0_valid=1 -> ready=0, we=0, conflict_cnt=0; after release, the slot is empty and ready=1.
- Single write: req0 (addr=1, data=0x0000000A) accepted at edge E -> cycle after E shows we=1, a3=1, wd3=0x0A, and BR reg1 reads 0x0A from then on; req0_ready stays 1 for back-to-back streaming of addr 2..5.
- Conflict round-robin:
  - Stimulus: both requesters valid in the same cycle with (3, 0x11) and (4, 0x22), then (5, 0x33) and (6, 0x44).
  - Response: grants alternate 0,1,0,1; BR reads reg3=0x11, reg4=0x22, reg5=0x33, reg6=0x44; conflict_cnt increments per both-pending cycle; the loser's ready stays 0 while blocked.
- x0 drop: req1 addr=0, data=0xFFFFFFFF -> handshake completes, we never asserted, stall flags never set for qa=0.
- Hazard: slot0 pending addr=7 with qa1=7, qa2=8 -> stall1=1, stall2=0 until the write cycle ends; stall1 drops the cycle after we=1 with a3=7.
- Reset mid-operation: both slots pending (9, 0xAA) and (10, 0xBB), rst_n pulled low one cycle -> neither write reaches BR, prio=0, and the next conflict grants req0 first.
